// File: rtl/wb_pkg.sv
// Shared widths, default queue depths and the write-port entry type for the writeback controller.
package wb_pkg;
  localparam int RA_W            = 5;
  localparam int DATA_W          = 32;
  localparam int WBUF_DEPTH_DFLT = 2;
  localparam int LDQ_DEPTH_DFLT  = 4;

  typedef struct packed {
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wr_ent_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// Generic synchronous FIFO with registered storage; pop_dat shows the head combinationally.
// A push is taken when full only if a pop happens in the same cycle; pop on empty is ignored.
module wb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: ALU write buffer and in-order load queue share one registered RF write port.
// ALU->we 2 cycles, load response->we 1 cycle; readys drop when full unless popping. WB_BYPASS_EN adds bypass outputs.
module reg_wb_ctrl
  import wb_pkg::*;
#(
  parameter int WBUF_DEPTH = WBUF_DEPTH_DFLT,
  parameter int LDQ_DEPTH  = LDQ_DEPTH_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [RA_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_issue,
  input  logic [RA_W-1:0]   ld_rd,
  output logic              ld_ready,
  input  logic              ld_resp_valid,
  input  logic [DATA_W-1:0] ld_resp_data,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              we,
  output logic [RA_W-1:0]   wa,
  output logic [DATA_W-1:0] wd,
  output logic              err
`ifdef WB_BYPASS_EN
  ,
  output logic              byp1_valid,
  output logic [DATA_W-1:0] byp1_data,
  output logic              byp2_valid,
  output logic [DATA_W-1:0] byp2_data
`endif
);
  logic [2**RA_W-1:0] busy;
  logic [2**RA_W-1:0] busy_nxt;
  wr_ent_t            wb_head;
  wr_ent_t            alu_ent;
  wr_ent_t            sel;
  logic [RA_W-1:0]    lq_head;
  logic               wb_full, wb_empty, lq_full, lq_empty;
  logic               wb_push, wb_pop, ld_pop, ld_acc, sel_vld;

  // Load responses own the write port; the buffer drains only in cycles without one.
  assign ld_pop    = ld_resp_valid && !lq_empty;
  assign wb_pop    = !wb_empty && !ld_pop;
  assign sel_vld   = ld_pop || wb_pop;
  assign alu_ready = !wb_full || wb_pop;
  assign wb_push   = alu_valid && alu_ready && (alu_rd != '0);
  assign ld_ready  = (!lq_full || ld_pop) && !((ld_rd != '0) && busy[ld_rd]);
  assign ld_acc    = ld_issue && ld_ready;
  assign alu_ent   = '{rd: alu_rd, data: alu_data};

  wb_sync_fifo #(.WIDTH($bits(wr_ent_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wb_push),
    .push_dat (alu_ent),
    .pop      (wb_pop),
    .pop_dat  (wb_head),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  wb_sync_fifo #(.WIDTH(RA_W), .DEPTH(LDQ_DEPTH)) u_ldq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ld_acc),
    .push_dat (ld_rd),
    .pop      (ld_pop),
    .pop_dat  (lq_head),
    .full     (lq_full),
    .empty    (lq_empty)
  );

  always_comb begin
    sel = wb_head;
    if (ld_pop) sel = '{rd: lq_head, data: ld_resp_data};
  end

  always_comb begin
    busy_nxt = busy;
    if (ld_pop && (lq_head != '0)) busy_nxt[lq_head] = 1'b0;
    if (ld_acc && (ld_rd != '0))   busy_nxt[ld_rd]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
      err  <= 1'b0;
      busy <= '0;
    end else begin
      we   <= sel_vld && (sel.rd != '0);
      busy <= busy_nxt;
      if (sel_vld && (sel.rd != '0)) begin
        wa <= sel.rd;
        wd <= sel.data;
      end
      if (ld_resp_valid && lq_empty) err <= 1'b1;
    end
  end

  assign hazard1 = busy[ra1] && (ra1 != '0);
  assign hazard2 = busy[ra2] && (ra2 != '0);

`ifdef WB_BYPASS_EN
  // Copy of the most recent buffer push; it is the newest entry whenever the buffer is non-empty.
  wr_ent_t wb_last;

  always_ff @(posedge clk) begin
    if (!rst_n)       wb_last <= '0;
    else if (wb_push) wb_last <= alu_ent;
  end

  always_comb begin
    byp1_valid = 1'b0;
    byp1_data  = '0;
    byp2_valid = 1'b0;
    byp2_data  = '0;
    if (ra1 != '0) begin
      if (!wb_empty && (wb_last.rd == ra1)) begin
        byp1_valid = 1'b1;
        byp1_data  = wb_last.data;
      end else if (we && (wa == ra1)) begin
        byp1_valid = 1'b1;
        byp1_data  = wd;
      end
    end
    if (ra2 != '0) begin
      if (!wb_empty && (wb_last.rd == ra2)) begin
        byp2_valid = 1'b1;
        byp2_data  = wb_last.data;
      end else if (we && (wa == ra2)) begin
        byp2_valid = 1'b1;
        byp2_data  = wd;
      end
    end
  end
`endif
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: expected RF writes queue up as stimulus is driven and are checked in commit order.
module tb_reg_wb_ctrl;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid;
  logic [RA_W-1:0]   alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_issue;
  logic [RA_W-1:0]   ld_rd;
  logic              ld_ready;
  logic              ld_resp_valid;
  logic [DATA_W-1:0] ld_resp_data;
  logic [RA_W-1:0]   ra1, ra2;
  logic              hazard1, hazard2;
  logic              we;
  logic [RA_W-1:0]   wa;
  logic [DATA_W-1:0] wd;
  logic              err;
`ifdef WB_BYPASS_EN
  logic              byp1_valid, byp2_valid;
  logic [DATA_W-1:0] byp1_data, byp2_data;
`endif

  wr_ent_t sb[$];
  wr_ent_t got;
  int      n_pass  = 0;
  int      n_fail  = 0;
  int      n_total = 0;

  reg_wb_ctrl #(.WBUF_DEPTH(2), .LDQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_rd         (ld_rd),
    .ld_ready      (ld_ready),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_data  (ld_resp_data),
    .ra1           (ra1),
    .ra2           (ra2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .we            (we),
    .wa            (wa),
    .wd            (wd),
    .err           (err)
`ifdef WB_BYPASS_EN
    ,
    .byp1_valid    (byp1_valid),
    .byp1_data     (byp1_data),
    .byp2_valid    (byp2_valid),
    .byp2_data     (byp2_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d);
    sb.push_back('{rd: rd, data: d});
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 64'(we), 64'd0);
      end else begin
        got = sb.pop_front();
        chk("wr_order", {27'd0, wa, wd}, {27'd0, got.rd, got.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_rd = '0; ld_resp_valid = 1'b0; ld_resp_data = '0;
    ra1 = 5'd5; ra2 = 5'd9;
    repeat (3) tick();
    chk("rst_we",   64'(we),   64'd0);
    chk("rst_wa",   64'(wa),   64'd0);
    chk("rst_wd",   64'(wd),   64'd0);
    chk("rst_err",  64'(err),  64'd0);
    chk("rst_haz",  {62'd0, hazard1, hazard2}, 64'd0);
    chk("rst_rdy",  {62'd0, alu_ready, ld_ready}, 64'd3);
    rst_n = 1'b1;
    tick();

    // ALU write: accepted at cycle 0, strobe at cycle 2 for exactly one cycle
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 chk("s1_alu_ready", 64'(alu_ready), 64'd1);
    exp_wr(5'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    chk("s1_we_c1", 64'(we), 64'd0);
    tick();
    chk("s1_we_c2", {27'd0, we, wa, wd}, {27'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    tick();
    chk("s1_pulse", 64'(we), 64'd0);

    // Load hazard on rd 7 until its response commits
    ld_issue = 1'b1; ld_rd = 5'd7; ra1 = 5'd7;
    #1 chk("s2_ld_ready", 64'(ld_ready), 64'd1);
    chk("s2_haz_pre", 64'(hazard1), 64'd0);
    tick();
    ld_issue = 1'b0;
    #1 chk("s2_haz_set", 64'(hazard1), 64'd1);
    repeat (3) tick();
    chk("s2_haz_hold", 64'(hazard1), 64'd1);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h1234;
    exp_wr(5'd7, 32'h1234);
    tick();
    ld_resp_valid = 1'b0;
    chk("s2_we_wa", {58'd0, we, wa}, {58'd0, 1'b1, 5'd7});
    chk("s2_haz_clr", 64'(hazard1), 64'd0);
    tick();

    // Three ALU requests against a full buffer and two load responses
    ld_issue = 1'b1; ld_rd = 5'd9; tick();
    ld_rd = 5'd10; tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    tick();
    alu_rd = 5'd2; alu_data = 32'hA2;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h900;
    exp_wr(5'd9, 32'h900);
    #1 chk("s3_ready_c1", 64'(alu_ready), 64'd1);
    tick();
    alu_rd = 5'd3; alu_data = 32'hA3; ld_resp_data = 32'hA00;
    exp_wr(5'd10, 32'hA00);
    #1 chk("s3_ready_low", 64'(alu_ready), 64'd0);
    tick();
    ld_resp_valid = 1'b0;
    #1 chk("s3_ready_back", 64'(alu_ready), 64'd1);
    exp_wr(5'd1, 32'hA1);
    exp_wr(5'd2, 32'hA2);
    exp_wr(5'd3, 32'hA3);
    tick();
    alu_valid = 1'b0;
    drain("s3_drain", 20);

    // Load queue fill, pop-enables-push, busy refusal
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_rd = 5'(i);
      #1 chk("s4_ld_ready", 64'(ld_ready), 64'd1);
      tick();
    end
    ld_rd = 5'd5;
    #1 chk("s4_full", 64'(ld_ready), 64'd0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h1001;
    #1 chk("s4_pop_push", 64'(ld_ready), 64'd1);
    exp_wr(5'd1, 32'h1001);
    tick();
    ld_issue = 1'b0; ld_resp_data = 32'h1002;
    exp_wr(5'd2, 32'h1002);
    tick();
    ld_resp_valid = 1'b0;
    ld_issue = 1'b1; ld_rd = 5'd3;
    #1 chk("s4_busy_refuse", 64'(ld_ready), 64'd0);
    ld_rd = 5'd6;
    #1 chk("s4_free_ok", 64'(ld_ready), 64'd1);
    ld_issue = 1'b0;
    for (int r = 3; r <= 5; r++) begin
      ld_resp_valid = 1'b1; ld_resp_data = 32'h1000 + 32'(r);
      exp_wr(5'(r), 32'h1000 + 32'(r));
      tick();
    end
    ld_resp_valid = 1'b0;
    drain("s4_drain", 10);

    // rd 0 traffic never writes; stray response raises sticky err
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    #1 chk("s5_alu0_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    ld_issue = 1'b1; ld_rd = 5'd0;
    #1 chk("s5_ld0_ready", 64'(ld_ready), 64'd1);
    tick();
    ld_issue = 1'b0;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h5555;
    tick();
    ld_resp_valid = 1'b0;
    chk("s5_rd0_consumed", 64'(err), 64'd0);
    chk("s5_rd0_no_we", 64'(we), 64'd0);
    repeat (2) tick();
    ld_resp_valid = 1'b1; ld_resp_data = 32'h6666;
    tick();
    ld_resp_valid = 1'b0;
    chk("s5_err_set", 64'(err), 64'd1);
    chk("s5_err_no_we", 64'(we), 64'd0);
    repeat (3) tick();
    chk("s5_err_sticky", 64'(err), 64'd1);

    // Reset with two loads outstanding
    ld_issue = 1'b1; ld_rd = 5'd11; tick();
    ld_rd = 5'd12; tick();
    ld_issue = 1'b0; ra1 = 5'd11; ra2 = 5'd12;
    #1 chk("s6_haz_pre", {62'd0, hazard1, hazard2}, 64'd3);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("s6_rst_outs", {26'd0, we, wa, wd, err}, 64'd0);
    chk("s6_rst_haz", {62'd0, hazard1, hazard2}, 64'd0);
    rst_n = 1'b1;
    tick();
    ld_resp_valid = 1'b1; ld_resp_data = 32'h7777;
    tick();
    ld_resp_valid = 1'b0;
    chk("s6_err_after", 64'(err), 64'd1);
    chk("s6_no_we", 64'(we), 64'd0);
    repeat (2) tick();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameters (name, default, meaning):
- WBUF_DEPTH, 2: ALU write-buffer entries.
- LDQ_DEPTH, 4: maximum outstanding loads.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- alu_valid, in, 1: ALU writeback request.
- alu_rd, in, 5: ALU destination register.
- alu_data, in, 32: ALU result.
- alu_ready, out, 1: write buffer not full.
- ld_issue, in, 1: load issued.
- ld_rd, in, 5: load destination register.
- ld_ready, out, 1: low when the load queue is full, or when ld_rd != 0 and busy[ld_rd].
- ld_resp_valid, in, 1: load data return, in order, no backpressure.
- ld_resp_data, in, 32: load data.
- ra1, in, 5: read address 1, for hazard query.
- ra2, in, 5: read address 2, for hazard query.
- hazard1, out, 1: ra1 has a pending load write, combinational.
- hazard2, out, 1: ra2 has a pending load write, combinational.
- we, out, 1: registered register-file write strobe.
- wa, out, 5: registered register-file write address.
- wd, out, 32: registered register-file write data.
- err, out, 1: sticky protocol error.

Function
REQ-004 ALU handshake: a request is accepted when alu_valid && alu_ready; accepted requests with alu_rd != 0 are pushed to the write buffer; alu_rd == 0 requests are accepted and discarded.
REQ-005 Load handshake: a load is accepted when ld_issue && ld_ready; ld_rd is pushed to the load queue; busy[ld_rd] is set when ld_rd != 0.
REQ-006 Write-port arbitration each cycle, highest priority first:
- (a) ld_resp_valid with a non-empty load queue: pop the queue head; the write is {head rd, ld_resp_data}.
- (b) non-empty write buffer: pop the buffer head.
- (c) no write.
REQ-007 A chosen write with rd == 0 SHALL leave we = 0 in the next cycle; otherwise we, wa and wd SHALL be registered on the next edge, so latency from selection to we is 1 cycle.
REQ-008 busy[rd] SHALL clear in the same edge that registers that load's write; hazardN = busy[raN] && raN != 0.
REQ-009 An ALU request SHALL never bypass the write buffer; the minimum latency from alu_valid to we is 2 cycles.
REQ-010 A push and a pop of the write buffer in the same cycle SHALL be legal when the buffer is full, and alu_ready = !full || pop_this_cycle.
REQ-011 A simultaneous load issue and response in the same cycle SHALL be legal at any queue occupancy, with the same pop-enables-push rule for ld_ready.
REQ-012 ld_resp_valid with an empty load queue SHALL drop the data and set err; err clears only on reset.
REQ-013 Writes SHALL commit in the arbitration order of REQ-006 only; upstream guarantees there is no ALU write to a register that is busy.

Reset
REQ-014 While rst_n == 0 at a clock edge:
- we = 0, wa = 0, wd = 0, err = 0.
- Both queues are emptied and all busy bits are cleared.
REQ-015 Loads outstanding at reset SHALL be forgotten; a response arriving after reset SHALL follow REQ-012.

Configuration
REQ-016 With WB_BYPASS_EN defined, the block SHALL add outputs byp1_valid/byp1_data and byp2_valid/byp2_data.
- bypN_valid SHALL be asserted when raN != 0 matches the newest write-buffer entry or the registered wa while we is high.
- Priority: the newest buffer entry first, then the registered write.
REQ-017 Without WB_BYPASS_EN, those ports SHALL be absent and the behaviour is otherwise identical.

Structure
REQ-018 Package wb_pkg SHALL hold the register-address width (5), data width (32), and the default WBUF_DEPTH and LDQ_DEPTH.
REQ-019 Package wb_pkg SHALL hold the write-entry type {rd[4:0], data[31:0]}.
REQ-020 Both queues SHALL instantiate one sub-module, wb_sync_fifo (parameterized width and depth, registered storage, full/empty flags).

Verification
REQ-021 Directed scenarios:
- ALU request rd=5, data=0xDEADBEEF at cycle 0 -> we=1, wa=5, wd=0xDEADBEEF at cycle 2; single-cycle pulse.
- ld_issue rd=7, then ra1=7 -> hazard1=1 until the response 0x1234 commits; we=1, wa=7, then hazard1=0 on the same edge.
- ALU requests on 3 consecutive cycles with WBUF_DEPTH=2 and a concurrent load response -> alu_ready drops; the load write precedes the buffered writes; all three ALU writes eventually appear in order.
- Issue 4 loads (rd 1..4) -> ld_ready=0 on the fifth; ld_issue with rd busy -> refused; responses write rd 1..4 in order.
- ALU rd=0 and load rd=0 -> no we ever; the load-queue entry is still consumed by its response; ld_resp_valid with an empty queue -> err=1, sticky.
- Reset asserted with 2 loads outstanding -> all outputs 0, hazards clear; a subsequent response sets err=1 and produces no write.
